// File: rtl/alu_cmd_driver.sv
// Initiator for the registered 4-bit ALU: buffers commands in a FIFO,
// sequences them onto the ALU ports and returns captured results.
module alu_cmd_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_select,
  input  logic [15:0]      alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [3:0]       res_op,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] OP_DIV = 4'd4;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } state_e;

  cmd_t mem_q [FIFO_DEPTH];
  cmd_t cmd_in;
  cmd_t head;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] cnt;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        slot_free;
  logic        div0;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  alu_a_q, alu_a_d;
  logic [3:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_data_q, res_data_d;
  logic [3:0]  res_op_q, res_op_d;
  logic        res_err_q, res_err_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  always_comb begin
    cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
    cnt       = wr_q - rd_q;
    empty     = (cnt == '0);
    full      = (cnt == DEPTH);
    head      = mem_q[rd_q[AW-1:0]];
    slot_free = !res_valid_q || res_ready;
    push      = cmd_valid && !full;
    pop       = (state_q == IDLE) && !empty && slot_free;
    div0      = (head.op == OP_DIV) && (head.b == 4'd0);
    wr_d      = wr_q + (AW+1)'(push);
    rd_d      = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= cmd_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    ops_d       = ops_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
      ops_d       = ops_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          if (div0) begin
            // trapped locally; the ALU never sees a zero divisor
            res_valid_d = 1'b1;
            res_data_d  = 16'hFFFF;
            res_op_d    = OP_DIV;
            res_err_d   = 1'b1;
          end else begin
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_sel_d = head.op;
            op_d      = head.op;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        alu_sel_d = 4'd0;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_result;
        res_op_d    = op_q;
        res_err_d   = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      state_q     <= IDLE;
      op_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      ops_q       <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      state_q     <= state_d;
      op_q        <= op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
      ops_q       <= ops_d;
    end
  end

  assign cmd_ready  = !full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign res_err    = res_err_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign ops_done   = ops_q;

endmodule
